// File: rtl/core_pkg.sv
// Shared core types: datapath widths, the write-back entry record and the
// write-port grant source.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_src_t;

    // x0 is architecturally constant, so writes to it are consumed but dropped.
    function automatic logic writes_reg(input logic [REG_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO of write-back entries used to buffer load responses until
// they win the register-file write port.
module wb_load_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  wb_entry_t        push_data_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count guards every read,
    // and leaving it out keeps the array mappable to plain RAM/flops.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port driver: round-robin between ALU results and buffered
// load responses, plus a pending-load scoreboard. Optional WB_BYPASS_EN adds a
// forwarding path from the registered write back to the issue-stage operands.
module writeback_unit
    import core_pkg::*;
#(
    parameter int XLEN     = core_pkg::XLEN,
    parameter int REG_AW   = core_pkg::REG_AW,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              mem_ready,
    input  logic              ld_issue_valid,
    input  logic [REG_AW-1:0] ld_issue_rd,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [REG_AW-1:0] wb_addr_rd,
    output logic [XLEN-1:0]   wb_data_rd,
    output logic              wb_write_enable
`ifdef WB_BYPASS_EN
   ,output logic              byp_rs1_hit,
    output logic              byp_rs2_hit,
    output logic [XLEN-1:0]   byp_data
`endif
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    if (XLEN != core_pkg::XLEN || REG_AW != core_pkg::REG_AW) begin : g_width_check
        $error("writeback_unit: XLEN/REG_AW must match core_pkg widths");
    end
    if (LQ_DEPTH < 2 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0) begin : g_depth_check
        $error("writeback_unit: LQ_DEPTH must be a power of two >= 2");
    end

    wb_entry_t        lq_head;
    wb_entry_t        lq_push_data;
    wb_entry_t        sel_entry;
    logic [CNT_W-1:0] lq_count;
    logic             lq_full;
    logic             lq_empty;
    logic             lq_push;

    logic             head_valid;
    logic             grant_alu;
    logic             grant_mem;
    logic             any_grant;
    logic             contended;
    grant_src_t       last_grant_q;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                wb_we_q;
    logic [REG_AW-1:0]   wb_addr_q;
    logic [XLEN-1:0]     wb_data_q;

    // Load buffer: readiness is based purely on the registered count.
    assign mem_ready    = (lq_count != CNT_W'(LQ_DEPTH)) && !reset;
    assign lq_push      = mem_valid && !lq_full && !reset;
    assign lq_push_data = '{rd: mem_rd, data: mem_data};

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (lq_push),
        .push_data_i (lq_push_data),
        .pop_i       (grant_mem),
        .head_o      (lq_head),
        .count_o     (lq_count),
        .full_o      (lq_full),
        .empty_o     (lq_empty)
    );

    // Round-robin only matters when both sources compete for the port.
    assign head_valid = !lq_empty && !reset;
    assign contended  = head_valid && alu_valid;
    assign grant_mem  = head_valid && (!alu_valid || last_grant_q == GRANT_ALU);
    assign grant_alu  = alu_valid && !reset && (!head_valid || last_grant_q == GRANT_MEM);
    assign any_grant  = grant_mem || grant_alu;
    assign alu_ready  = grant_alu;
    assign sel_entry  = grant_mem ? lq_head : '{rd: alu_rd, data: alu_data};

    // Set wins over clear so a re-issued load to the same rd stays tracked.
    always_comb begin
        pending_d = pending_q;
        if (grant_mem) begin
            pending_d[lq_head.rd] = 1'b0;
        end
        if (ld_issue_valid) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_we_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            last_grant_q <= GRANT_ALU;
            pending_q    <= '0;
        end else begin
            wb_we_q   <= any_grant && writes_reg(sel_entry.rd);
            pending_q <= pending_d;
            if (any_grant) begin
                wb_addr_q <= sel_entry.rd;
                wb_data_q <= sel_entry.data;
            end
            if (contended) begin
                last_grant_q <= grant_mem ? GRANT_MEM : GRANT_ALU;
            end
        end
    end

    assign wb_write_enable = wb_we_q;
    assign wb_addr_rd      = wb_addr_q;
    assign wb_data_rd      = wb_data_q;
    assign rs1_busy        = pending_q[q_rs1];
    assign rs2_busy        = pending_q[q_rs2];

`ifdef WB_BYPASS_EN
    // Covers the read-during-write case where the register file returns old data.
    assign byp_rs1_hit = wb_we_q && (wb_addr_q == q_rs1) && writes_reg(wb_addr_q);
    assign byp_rs2_hit = wb_we_q && (wb_addr_q == q_rs2) && writes_reg(wb_addr_q);
    assign byp_data    = wb_data_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: reset, ALU table, contention,
// load buffer / scoreboard sequences, and the bypass path when WB_BYPASS_EN is set.
module tb_writeback_unit;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  wb_addr_rd;
    logic [31:0] wb_data_rd;
    logic        wb_write_enable;
`ifdef WB_BYPASS_EN
    logic        byp_rs1_hit;
    logic        byp_rs2_hit;
    logic [31:0] byp_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] tb_pend = '0;

    writeback_unit #(.XLEN(32), .REG_AW(5), .LQ_DEPTH(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .ld_issue_valid  (ld_issue_valid),
        .ld_issue_rd     (ld_issue_rd),
        .q_rs1           (q_rs1),
        .q_rs2           (q_rs2),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .wb_addr_rd      (wb_addr_rd),
        .wb_data_rd      (wb_data_rd),
        .wb_write_enable (wb_write_enable)
`ifdef WB_BYPASS_EN
       ,.byp_rs1_hit     (byp_rs1_hit),
        .byp_rs2_hit     (byp_rs2_hit),
        .byp_data        (byp_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_we;
        logic        chk_ad;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } alu_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        mem_valid      = 1'b0;
        mem_rd         = '0;
        mem_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        tb_pend = '0;
    endtask

    // Re-issuing to a pending rd is only legal in the cycle its old load retires.
    task automatic issue_load(input logic [4:0] rd, input logic retiring_same_cycle);
        assert (!tb_pend[rd] || retiring_same_cycle)
            else $error("illegal second load issued to pending rd %0d", rd);
        ld_issue_valid = 1'b1;
        ld_issue_rd    = rd;
        if (rd != 0) tb_pend[rd] = 1'b1;
    endtask

    task automatic expect_write(input string name, input logic [4:0] addr, input logic [31:0] data);
        check({name, " we"},   32'(wb_write_enable), 32'd1);
        check({name, " addr"}, 32'(wb_addr_rd), 32'(addr));
        check({name, " data"}, wb_data_rd, data);
    endtask

    alu_vec_t vecs [6];
    logic     exp_ar   [4];
    logic     exp_mr   [4];
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd9,  32'h0BADF00D, 1'b0, 1'b0, 1'b1, 5'd7,  32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 1'b1, 1'b1, 5'd1,  32'h00000001};
        vecs[5] = '{1'b0, 5'd1,  32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 5'd1,  32'h00000001};

        exp_ar = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_mr = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_a  = '{5'd3, 5'd4, 5'd3, 5'd4};
        exp_d  = '{32'hAA, 32'hBB, 32'hAA, 32'hBB};

        // ---------------- reset held 3 cycles with an ALU request pending
        idle_inputs();
        q_rs1     = '0;
        q_rs2     = '0;
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            check("reset we", 32'(wb_write_enable), 32'd0);
            check("reset alu_ready", 32'(alu_ready), 32'd0);
        end
        reset     = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("reset addr", 32'(wb_addr_rd), 32'd0);
        check("reset data", wb_data_rd, 32'd0);
        check("reset mem_ready", 32'(mem_ready), 32'd1);
        for (int r = 0; r < 32; r++) begin
            q_rs1 = 5'(r);
            #1;
            check($sformatf("reset rs1_busy[%0d]", r), 32'(rs1_busy), 32'd0);
        end
        @(negedge clock);

        // ---------------- ALU-only path (table driven)
        for (int i = 0; i < 6; i++) begin
            alu_valid = vecs[i].v;
            alu_rd    = vecs[i].rd;
            alu_data  = vecs[i].data;
            #1;
            check($sformatf("alu vec%0d ready", i), 32'(alu_ready), 32'(vecs[i].exp_ready));
            @(negedge clock);
            check($sformatf("alu vec%0d we", i), 32'(wb_write_enable), 32'(vecs[i].exp_we));
            if (vecs[i].chk_ad) begin
                check($sformatf("alu vec%0d addr", i), 32'(wb_addr_rd), 32'(vecs[i].exp_addr));
                check($sformatf("alu vec%0d data", i), wb_data_rd, vecs[i].exp_data);
            end
        end

        // ---------------- contention: MEM first (last_grant = ALU after reset), then alternate
        apply_reset();
        mem_valid = 1'b1;
        mem_rd    = 5'd3;
        mem_data  = 32'hAA;
        #1;
        check("cont push mem_ready", 32'(mem_ready), 32'd1);
        check("cont push alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clock);
        check("cont push we", 32'(wb_write_enable), 32'd0);
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'hBB;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("cont c%0d alu_ready", c), 32'(alu_ready), 32'(exp_ar[c]));
            check($sformatf("cont c%0d mem_ready", c), 32'(mem_ready), 32'(exp_mr[c]));
            @(negedge clock);
            expect_write($sformatf("cont c%0d", c), exp_a[c], exp_d[c]);
        end

        // ---------------- load buffer and scoreboard
        apply_reset();
        q_rs1 = 5'd9;
        q_rs2 = 5'd8;
        issue_load(5'd8, 1'b0);                       // S0
        #1;
        check("sb s0 rs2_busy", 32'(rs2_busy), 32'd0);
        @(negedge clock);
        issue_load(5'd9, 1'b0);                       // S1
        mem_valid = 1'b1;
        mem_rd    = 5'd8;
        mem_data  = 32'h88;
        #1;
        check("sb s1 rs1_busy", 32'(rs1_busy), 32'd0);
        check("sb s1 rs2_busy", 32'(rs2_busy), 32'd1);
        @(negedge clock);
        ld_issue_valid = 1'b0;                        // S2: both compete, MEM wins
        mem_valid      = 1'b0;
        alu_valid      = 1'b1;
        alu_rd         = 5'd4;
        alu_data       = 32'h44;
        #1;
        check("sb s2 alu_ready", 32'(alu_ready), 32'd0);
        check("sb s2 rs1_busy", 32'(rs1_busy), 32'd1);
        check("sb s2 rs2_busy", 32'(rs2_busy), 32'd1);
        @(negedge clock);
        tb_pend[8] = 1'b0;
        expect_write("sb s2", 5'd8, 32'h88);
        check("sb s2 rs2 cleared", 32'(rs2_busy), 32'd0);
        mem_valid = 1'b1;                             // S3: FIFO empty, ALU alone
        mem_rd    = 5'd9;
        mem_data  = 32'h99;
        alu_data  = 32'h45;
        #1;
        check("sb s3 alu_ready", 32'(alu_ready), 32'd1);
        check("sb s3 mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clock);
        expect_write("sb s3", 5'd4, 32'h45);
        check("sb s3 rs1_busy", 32'(rs1_busy), 32'd1);
        mem_rd   = 5'd10;                             // S4: last=MEM, ALU wins, FIFO fills
        mem_data = 32'hA0;
        alu_data = 32'h46;
        #1;
        check("sb s4 alu_ready", 32'(alu_ready), 32'd1);
        check("sb s4 mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clock);
        expect_write("sb s4", 5'd4, 32'h46);
        alu_data = 32'h47;                            // S5: full after 2 pushes, MEM wins
        #1;
        check("sb s5 mem_ready full", 32'(mem_ready), 32'd0);
        check("sb s5 alu_ready", 32'(alu_ready), 32'd0);
        check("sb s5 rs1_busy", 32'(rs1_busy), 32'd1);
        @(negedge clock);
        tb_pend[9] = 1'b0;
        expect_write("sb s5", 5'd9, 32'h99);
        check("sb s5 rs1 cleared", 32'(rs1_busy), 32'd0);
        mem_valid = 1'b0;                             // S6: head rd10 alone
        alu_valid = 1'b0;
        issue_load(5'd9, 1'b0);
        #1;
        check("sb s6 alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clock);
        expect_write("sb s6", 5'd10, 32'hA0);
        check("sb s6 rs1_busy", 32'(rs1_busy), 32'd1);
        ld_issue_valid = 1'b0;                        // S7: push rd9 response, no grant yet
        mem_valid      = 1'b1;
        mem_rd         = 5'd9;
        mem_data       = 32'h9B;
        #1;
        check("sb s7 mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clock);
        check("sb s7 we", 32'(wb_write_enable), 32'd0);
        mem_valid = 1'b0;                             // S8: clear and re-issue rd9 together
        issue_load(5'd9, 1'b1);
        #1;
        check("sb s8 rs1_busy", 32'(rs1_busy), 32'd1);
        @(negedge clock);
        expect_write("sb s8", 5'd9, 32'h9B);
        check("sb s8 set wins", 32'(rs1_busy), 32'd1);
        issue_load(5'd0, 1'b0);                       // S9: x0 is never pending
        @(negedge clock);
        ld_issue_valid = 1'b0;
        q_rs1 = 5'd0;
        #1;
        check("sb x0 busy", 32'(rs1_busy), 32'd0);
        q_rs1 = 5'd9;
        #1;
        check("sb rd9 still busy", 32'(rs1_busy), 32'd1);

`ifdef WB_BYPASS_EN
        // ---------------- bypass from the registered write
        @(negedge clock);
        alu_valid = 1'b1;
        alu_rd    = 5'd12;
        alu_data  = 32'h55;
        @(negedge clock);
        alu_valid = 1'b0;
        q_rs1     = 5'd0;
        q_rs2     = 5'd12;
        #1;
        check("byp rs2_hit", 32'(byp_rs2_hit), 32'd1);
        check("byp data", byp_data, 32'h55);
        check("byp rs1_hit x0", 32'(byp_rs1_hit), 32'd0);
        q_rs2 = 5'd0;
        #1;
        check("byp rs2_hit x0", 32'(byp_rs2_hit), 32'd0);
`endif

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
